// File: rtl/mfp_ahb_lite_arbiter_2m_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mfp_ahb_lite_arbiter_2m_pkg
// Description : Shared encodings for the two-master AHB-Lite arbiter.
//               Holds the HTRANS/HBURST codes, the arbitration mode values,
//               the per-master state type and the request decode.
// Revision    : 1.0 - initial release
// ============================================================================
package mfp_ahb_lite_arbiter_2m_pkg;

    localparam logic [1:0] c_htrans_idle   = 2'b00;
    localparam logic [1:0] c_htrans_busy   = 2'b01;
    localparam logic [1:0] c_htrans_nonseq = 2'b10;
    localparam logic [1:0] c_htrans_seq    = 2'b11;

    localparam logic [2:0] c_hburst_single = 3'b000;

    localparam int c_arb_round_robin = 0;
    localparam int c_arb_fixed_m1    = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,   // nothing buffered, master sees HREADY=1
        ST_PEND   = 2'd1,   // address buffered, not yet accepted by slave
        ST_ISSUED = 2'd2    // data phase of this master is on the slave
    } port_state_e;

    // Masters are single-transfer, so SEQ is just another NONSEQ. Only
    // HTRANS[1]=1 codes start a transfer; BUSY carries no address.
    function automatic logic is_request(input logic [1:0] htrans);
        return (htrans == c_htrans_nonseq) || (htrans == c_htrans_seq);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mfp_ahb_lite_arb_port.sv
`default_nettype none
// ============================================================================
// Module      : mfp_ahb_lite_arb_port
// Description : One master-side port of the AHB-Lite arbiter. Buffers the
//               master's address phase and tracks it IDLE -> PEND -> ISSUED.
//   HCLK, HRESETn        bus clock, async active-low reset
//   i_htrans..i_hsize    master address-phase inputs
//   i_accept             this port's buffered address accepted this cycle
//   i_hready, i_hresp    slave response (meaningful while ISSUED)
//   o_hready, o_hresp    response returned to the master
//   o_pend               address buffered and waiting for the slave
//   o_addr/write/size    buffered address phase
// Revision    : 1.0 - initial release
// ============================================================================
module mfp_ahb_lite_arb_port
    import mfp_ahb_lite_arbiter_2m_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [1:0]  i_htrans,
    input  logic [31:0] i_haddr,
    input  logic        i_hwrite,
    input  logic [2:0]  i_hsize,
    input  logic        i_accept,
    input  logic        i_hready,
    input  logic        i_hresp,
    output logic        o_hready,
    output logic        o_hresp,
    output logic        o_pend,
    output logic [31:0] o_addr,
    output logic        o_write,
    output logic [2:0]  o_size
);

    port_state_e r_state;
    port_state_e w_next;
    logic        w_capture;
    logic        w_req;
    logic [31:0] r_addr;
    logic        r_write;
    logic [2:0]  r_size;

    assign w_req = is_request(i_htrans);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
            r_addr  <= 32'h0;
            r_write <= 1'b0;
            r_size  <= 3'b000;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_addr  <= i_haddr;
                r_write <= i_hwrite;
                r_size  <= i_hsize;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        o_hready  = 1'b1;
        o_hresp   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_capture = 1'b1;
                    w_next    = ST_PEND;
                end
            end
            ST_PEND: begin
                // Master is stalled in its data phase until ours reaches the slave.
                o_hready = 1'b0;
                if (i_accept) begin
                    w_next = ST_ISSUED;
                end
            end
            ST_ISSUED: begin
                o_hready = i_hready;
                o_hresp  = i_hresp;
                if (i_hready) begin
                    // Completion cycle doubles as the master's next address phase.
                    if (w_req) begin
                        w_capture = 1'b1;
                        w_next    = ST_PEND;
                    end else begin
                        w_next    = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign o_pend  = (r_state == ST_PEND);
    assign o_addr  = r_addr;
    assign o_write = r_write;
    assign o_size  = r_size;

endmodule
`default_nettype wire

// File: rtl/mfp_ahb_lite_arbiter_2m.sv
`default_nettype none
// ============================================================================
// Module      : mfp_ahb_lite_arbiter_2m
// Description : Two-master AHB-Lite arbiter (M0 = CPU, M1 = serial loader)
//               onto one slave bus. Each master's address is buffered, then
//               issued as a SINGLE NONSEQ transfer when the slave address
//               phase is free. ARB_MODE 0 = round-robin, 1 = M1 priority.
//   HCLK, HRESETn                     clock, async active-low reset
//   Mx_HADDR/HTRANS/HWRITE/HSIZE/HWDATA   master request side
//   Mx_HRDATA/HREADY/HRESP            master response side
//   HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA   slave request side
//   HRDATA/HREADY/HRESP               slave response side
// Revision    : 1.0 - initial release
// ============================================================================
module mfp_ahb_lite_arbiter_2m
    import mfp_ahb_lite_arbiter_2m_pkg::*;
#(
    parameter int ARB_MODE = c_arb_round_robin
)(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] M0_HADDR,
    input  logic [1:0]  M0_HTRANS,
    input  logic        M0_HWRITE,
    input  logic [2:0]  M0_HSIZE,
    input  logic [31:0] M0_HWDATA,
    output logic [31:0] M0_HRDATA,
    output logic        M0_HREADY,
    output logic        M0_HRESP,
    input  logic [31:0] M1_HADDR,
    input  logic [1:0]  M1_HTRANS,
    input  logic        M1_HWRITE,
    input  logic [2:0]  M1_HSIZE,
    input  logic [31:0] M1_HWDATA,
    output logic [31:0] M1_HRDATA,
    output logic        M1_HREADY,
    output logic        M1_HRESP,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    logic        w_pend0, w_pend1;
    logic [31:0] w_addr0, w_addr1;
    logic        w_write0, w_write1;
    logic [2:0]  w_size0, w_size1;
    logic        w_avail, w_present, w_accept, w_sel;

    logic        r_data_active;  // a data phase is on the slave
    logic        r_owner;        // master owning that data phase (1 = M1)
    logic        r_hold;         // address presented last cycle, not accepted
    logic        r_hold_mst;     // master whose address is being held
    logic        r_last;         // master granted most recently

    mfp_ahb_lite_arb_port u_port0 (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .i_htrans (M0_HTRANS),
        .i_haddr  (M0_HADDR),
        .i_hwrite (M0_HWRITE),
        .i_hsize  (M0_HSIZE),
        .i_accept (w_accept && !w_sel),
        .i_hready (HREADY),
        .i_hresp  (HRESP),
        .o_hready (M0_HREADY),
        .o_hresp  (M0_HRESP),
        .o_pend   (w_pend0),
        .o_addr   (w_addr0),
        .o_write  (w_write0),
        .o_size   (w_size0)
    );

    mfp_ahb_lite_arb_port u_port1 (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .i_htrans (M1_HTRANS),
        .i_haddr  (M1_HADDR),
        .i_hwrite (M1_HWRITE),
        .i_hsize  (M1_HSIZE),
        .i_accept (w_accept && w_sel),
        .i_hready (HREADY),
        .i_hresp  (HRESP),
        .o_hready (M1_HREADY),
        .o_hresp  (M1_HRESP),
        .o_pend   (w_pend1),
        .o_addr   (w_addr1),
        .o_write  (w_write1),
        .o_size   (w_size1)
    );

    assign w_avail = !r_data_active || HREADY;

    // A held address keeps its owner; otherwise arbitrate among PEND ports.
    always_comb begin
        w_sel = 1'b0;
        if (r_hold) begin
            w_sel = r_hold_mst;
        end else if (w_pend0 && w_pend1) begin
            w_sel = (ARB_MODE == c_arb_fixed_m1) ? 1'b1 : ~r_last;
        end else begin
            w_sel = w_pend1;
        end
    end

    assign w_present = r_hold || (w_avail && (w_pend0 || w_pend1));
    assign w_accept  = w_present && HREADY;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_data_active <= 1'b0;
            r_owner       <= 1'b0;
            r_hold        <= 1'b0;
            r_hold_mst    <= 1'b0;
            r_last        <= 1'b1;   // first tie goes to M0
        end else begin
            r_hold     <= w_present && !HREADY;
            r_hold_mst <= w_sel;
            if (w_accept) begin
                r_data_active <= 1'b1;
                r_owner       <= w_sel;
                r_last        <= w_sel;
            end else if (HREADY) begin
                r_data_active <= 1'b0;
                r_owner       <= 1'b0;
            end
        end
    end

    assign HTRANS = w_present ? c_htrans_nonseq : c_htrans_idle;
    assign HADDR  = w_sel ? w_addr1  : w_addr0;
    assign HWRITE = w_sel ? w_write1 : w_write0;
    assign HSIZE  = w_sel ? w_size1  : w_size0;
    assign HBURST = c_hburst_single;
    assign HWDATA = r_owner ? M1_HWDATA : M0_HWDATA;

    assign M0_HRDATA = HRDATA;
    assign M1_HRDATA = HRDATA;

endmodule
`default_nettype wire
